mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between instruction fetch (IF stage) and data access (MEM stage).

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and data access. Data has priority. An anti-starvation counter forces a
// fetch grant after STARVE_MAX consecutive data grants while a fetch waits.
//
// Memory handshake: mem_req is high only in REQ and holds mem_we/addr/wdata
// stable. The request is accepted on the first rising edge where
// mem_req && mem_ready. Exactly one mem_rvalid pulse later returns read data
// or a write ack. mem_ready is ignored outside REQ. mem_rvalid is ignored
// outside RESP.
// Requester side: a request is held stable until its 1-cycle valid pulse.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  localparam int CNT_W     = $clog2(STARVE_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic [1:0]        dbg_state,
  output logic [CNT_W-1:0]  dbg_starve_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_e            state_q, state_d;
  logic              owner_dm_q, owner_dm_d;  // 1 = data stage owns the port
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              dm_wins;

  // Data wins unless a fetch is waiting and the starvation limit is reached.
  assign dm_wins = dm_req && (!if_req || (starve_q < STARVE_LIM));

  // State register and latched transaction fields, all cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      owner_dm_q <= 1'b0;
      starve_q   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_dm_q <= owner_dm_d;
      starve_q   <= starve_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Next-state logic: grant in IDLE, hand off in REQ, capture in RESP.
  always_comb begin
    state_d    = state_q;
    owner_dm_d = owner_dm_q;
    starve_d   = starve_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (dm_wins) begin
          owner_dm_d = 1'b1;
          we_d       = dm_we;
          addr_d     = dm_addr;
          wdata_d    = dm_wdata;
          state_d    = S_REQ;
          if (if_req && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end else if (if_req) begin
          owner_dm_d = 1'b0;
          we_d       = 1'b0;
          addr_d     = if_addr;
          wdata_d    = '0;
          starve_d   = '0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (mem_rvalid) begin
          if (!owner_dm_q) begin
            if_rdata_d = mem_rdata;
          end else if (!we_q) begin
            dm_rdata_d = mem_rdata;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_req        = (state_q == S_REQ);
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign if_valid       = (state_q == S_DONE) && !owner_dm_q;
  assign dm_valid       = (state_q == S_DONE) && owner_dm_q;
  assign if_rdata       = if_rdata_q;
  assign dm_rdata       = dm_rdata_q;
  assign stall_if       = if_req && !if_valid;
  assign stall_mem      = dm_req && !dm_valid;
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a memory responder model with programmable
// accept/return delays, and scenario tasks with an expected-data queue.
module tb_mem_port_arbiter;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic        clk, rst;
  logic        if_req, if_valid, dm_req, dm_we, dm_valid;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_if, stall_mem;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_starve_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_grant_q[$];
  logic [2:0]  exp_cnt_q[$];
  logic [31:0] init_mem[logic [31:0]];
  logic [31:0] mem_model[logic [31:0]];
  logic [31:0] shadow[logic [31:0]];

  bit          rsp_enable;
  int          ready_delay, rvalid_delay;
  logic        rsp_ready, rsp_rvalid, man_ready, man_rvalid;
  logic [31:0] rsp_rdata, man_rdata;

  assign mem_ready  = rsp_enable ? rsp_ready  : man_ready;
  assign mem_rvalid = rsp_enable ? rsp_rvalid : man_rvalid;
  assign mem_rdata  = rsp_enable ? rsp_rdata  : man_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    if (init_mem.exists(a)) return init_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    if (shadow.exists(a)) return shadow[a];
    if (init_mem.exists(a)) return init_mem[a];
    return dflt(a);
  endfunction

  // Memory responder: accepts after ready_delay cycles, returns after rvalid_delay more.
  initial begin : responder
    int phase;
    int cnt;
    logic [31:0] a;
    phase = 0; cnt = 0; a = '0;
    rsp_ready = 1'b0; rsp_rvalid = 1'b0; rsp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      rsp_rvalid = 1'b0;
      if (!rst || !rsp_enable) begin
        phase = 0;
      end else if (phase == 2) begin
        if (cnt == 0) begin
          rsp_rvalid = 1'b1;
          rsp_rdata = mem_rd(a);
          phase = 0;
        end else cnt--;
      end else begin
        if (phase == 0 && mem_req) begin
          phase = 1;
          cnt = ready_delay;
        end
        if (phase == 1) begin
          if (cnt == 0) begin
            rsp_ready = 1'b1;
            phase = 2;
            cnt = rvalid_delay;
            a = mem_addr;
            if (mem_we) mem_model[mem_addr] = mem_wdata;
          end else cnt--;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    init_mem[a] = d;
  endtask

  task automatic wait_valid(input bit want_dm, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((want_dm && dm_valid) || (!want_dm && if_valid)) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({mem_req, mem_we, if_valid, dm_valid, stall_if, stall_mem} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 000000", {mem_req, mem_we, if_valid, dm_valid, stall_if, stall_mem});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_mem_fields addr=%h wdata=%h expected 0/0", mem_addr, mem_wdata);
    end
    checks++;
    if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata if=%h dm=%h expected 0/0", if_rdata, dm_rdata);
    end
    checks++;
    if (dbg_state !== ST_IDLE || dbg_starve_cnt !== 3'd0) begin
      errors++; $display("FAIL reset_state state=%0d cnt=%0d expected 0/0", dbg_state, dbg_starve_cnt);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (dbg_state !== ST_IDLE || mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_release state=%0d mem_req=%b expected 0/0", dbg_state, mem_req);
    end
  endtask

  task automatic test_if_fetch();
    logic [31:0] exp;
    rsp_enable = 1'b1; ready_delay = 0; rvalid_delay = 0;
    preload(32'h10, 32'h0050_0093);
    if_addr = 32'h10; if_req = 1'b1;
    exp_q.push_back(shadow_rd(32'h10));
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (stall_if !== 1'b1 || if_valid !== 1'b0) begin
        errors++; $display("FAIL if_stall_c%0d stall_if=%b if_valid=%b expected 1/0", c, stall_if, if_valid);
      end
      if (c == 1) begin
        checks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h10}) begin
          errors++; $display("FAIL if_mem_req req=%b we=%b addr=%h expected 1/0/00000010", mem_req, mem_we, mem_addr);
        end
      end
      tick();
    end
    checks++;
    if (if_valid !== 1'b1 || dm_valid !== 1'b0) begin
      errors++; $display("FAIL if_valid_c3 if_valid=%b dm_valid=%b expected 1/0", if_valid, dm_valid);
    end
    checks++;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    if (if_rdata !== exp) begin
      errors++; $display("FAIL if_rdata got %h expected %h", if_rdata, exp);
    end
    checks++;
    if (stall_if !== 1'b0) begin
      errors++; $display("FAIL if_stall_c3 got %b expected 0", stall_if);
    end
    tick();
    if_req = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL if_after_done if_valid=%b state=%0d expected 0/0", if_valid, dbg_state);
    end
  endtask

  task automatic test_dm_priority();
    logic [31:0] exp;
    preload(32'h100, 32'h1234_5678);
    preload(32'h20, 32'hAAAA_5555);
    if_addr = 32'h20; if_req = 1'b1;
    dm_addr = 32'h100; dm_we = 1'b0; dm_wdata = 32'h0; dm_req = 1'b1;
    exp_q.push_back(shadow_rd(32'h100));
    exp_q.push_back(shadow_rd(32'h20));
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || dbg_starve_cnt !== 3'd1) begin
      errors++; $display("FAIL prio_dm_grant req=%b addr=%h cnt=%0d expected 1/00000100/1", mem_req, mem_addr, dbg_starve_cnt);
    end
    tick(); tick();
    checks++;
    if (dm_valid !== 1'b1 || if_valid !== 1'b0) begin
      errors++; $display("FAIL prio_dm_valid dm_valid=%b if_valid=%b expected 1/0", dm_valid, if_valid);
    end
    checks++;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    if (dm_rdata !== exp) begin
      errors++; $display("FAIL prio_dm_rdata got %h expected %h", dm_rdata, exp);
    end
    tick();
    dm_req = 1'b0;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h20 || dbg_starve_cnt !== 3'd0) begin
      errors++; $display("FAIL prio_if_grant req=%b addr=%h cnt=%0d expected 1/00000020/0", mem_req, mem_addr, dbg_starve_cnt);
    end
    tick(); tick();
    checks++;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    if (if_valid !== 1'b1 || if_rdata !== exp) begin
      errors++; $display("FAIL prio_if_done valid=%b rdata=%h expected 1/%h", if_valid, if_rdata, exp);
    end
    tick();
    if_req = 1'b0;
  endtask

  task automatic test_starvation();
    logic [31:0] exp;
    bit prev_req, done;
    int ngrants, n_if, n_dm;
    preload(32'h300, 32'hC0FF_EE00);
    preload(32'h40, 32'h0BAD_F00D);
    for (int i = 0; i < 4; i++) begin
      exp_grant_q.push_back(32'h300);
      exp_cnt_q.push_back(3'(i + 1));
      exp_q.push_back(shadow_rd(32'h300));
    end
    exp_grant_q.push_back(32'h40);  exp_cnt_q.push_back(3'd0); exp_q.push_back(shadow_rd(32'h40));
    exp_grant_q.push_back(32'h300); exp_cnt_q.push_back(3'd1); exp_q.push_back(shadow_rd(32'h300));
    if_addr = 32'h40; if_req = 1'b1;
    dm_addr = 32'h300; dm_we = 1'b0; dm_req = 1'b1;
    prev_req = 1'b0; done = 1'b0; ngrants = 0; n_if = 0; n_dm = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      tick();
      if (mem_req && !prev_req) begin
        checks++;
        if (exp_grant_q.size() == 0) begin
          errors++; $display("FAIL starve_extra_grant addr=%h expected no grant", mem_addr);
        end else begin
          logic [31:0] ea;
          logic [2:0]  ec;
          ea = exp_grant_q.pop_front();
          ec = exp_cnt_q.pop_front();
          if (mem_addr !== ea || dbg_starve_cnt !== ec) begin
            errors++; $display("FAIL starve_grant%0d addr=%h cnt=%0d expected %h/%0d", ngrants, mem_addr, dbg_starve_cnt, ea, ec);
          end
        end
        ngrants++;
        if (ngrants == 6) if_req = 1'b0;
      end
      prev_req = mem_req;
      if (if_valid || dm_valid) begin
        checks++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        if ((if_valid && if_rdata !== exp) || (dm_valid && dm_rdata !== exp) || (if_valid && dm_valid)) begin
          errors++; $display("FAIL starve_data ifv=%b dmv=%b if=%h dm=%h expected %h", if_valid, dm_valid, if_rdata, dm_rdata, exp);
        end
        if (if_valid) n_if++;
        if (dm_valid) n_dm++;
        if (dm_valid && ngrants >= 6) begin
          done = 1'b1;
          break;
        end
      end
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL starve_timeout grants=%0d expected 6", ngrants);
    end
    tick();
    dm_req = 1'b0;
    checks++;
    if (n_if !== 1 || n_dm !== 5 || exp_grant_q.size() !== 0) begin
      errors++; $display("FAIL starve_counts if=%0d dm=%0d left=%0d expected 1/5/0", n_if, n_dm, exp_grant_q.size());
    end
  endtask

  task automatic test_store_wait();
    rsp_enable = 1'b1; ready_delay = 3; rvalid_delay = 0;
    dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; dm_we = 1'b1; dm_req = 1'b1;
    shadow[32'h200] = 32'hDEAD_BEEF;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF}) begin
        errors++; $display("FAIL store_hold_c%0d req=%b we=%b addr=%h wdata=%h expected 1/1/00000200/deadbeef", c, mem_req, mem_we, mem_addr, mem_wdata);
      end
    end
    tick();
    checks++;
    if (dm_valid !== 1'b0 || dbg_state !== ST_RESP) begin
      errors++; $display("FAIL store_resp dm_valid=%b state=%0d expected 0/2", dm_valid, dbg_state);
    end
    tick();
    checks++;
    if (dm_valid !== 1'b1 || dm_rdata !== 32'hC0FF_EE00) begin
      errors++; $display("FAIL store_ack dm_valid=%b dm_rdata=%h expected 1/c0ffee00", dm_valid, dm_rdata);
    end
    tick();
    dm_req = 1'b0; dm_we = 1'b0;
    checks++;
    if (mem_rd(32'h200) !== shadow_rd(32'h200)) begin
      errors++; $display("FAIL store_mem_content got %h expected %h", mem_rd(32'h200), shadow_rd(32'h200));
    end
    ready_delay = 0;
  endtask

  task automatic test_reset_mid();
    bit bad;
    rsp_enable = 1'b0; man_ready = 1'b0; man_rvalid = 1'b0; man_rdata = 32'h0;
    dm_addr = 32'h104; dm_we = 1'b0; dm_req = 1'b1;
    tick();
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    checks++;
    if (dbg_state !== ST_RESP) begin
      errors++; $display("FAIL rstmid_in_resp state=%0d expected 2", dbg_state);
    end
    rst = 1'b0; dm_req = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, if_valid, dm_valid} !== 4'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL rstmid_outputs req=%b we=%b ifv=%b dmv=%b addr=%h wdata=%h expected all 0", mem_req, mem_we, if_valid, dm_valid, mem_addr, mem_wdata);
    end
    checks++;
    if (if_rdata !== 32'h0 || dm_rdata !== 32'h0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL rstmid_regs if=%h dm=%h state=%0d expected 0/0/0", if_rdata, dm_rdata, dbg_state);
    end
    tick();
    rst = 1'b1;
    tick(); tick();
    man_rvalid = 1'b1; man_rdata = 32'h7777_7777;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      man_rvalid = 1'b0;
      if (if_valid || dm_valid || mem_req || dbg_state !== ST_IDLE) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL rstmid_late_rvalid activity seen expected idle");
    end
    checks++;
    if (dm_rdata !== 32'h0 || if_rdata !== 32'h0) begin
      errors++; $display("FAIL rstmid_late_capture if=%h dm=%h expected 0/0", if_rdata, dm_rdata);
    end
  endtask

  task automatic test_spurious();
    bit got, bad;
    rsp_enable = 1'b1; ready_delay = 0; rvalid_delay = 0;
    if_addr = 32'h10; if_req = 1'b1;
    wait_valid(1'b0, 20, got);
    checks++;
    if (!got || if_rdata !== 32'h0050_0093) begin
      errors++; $display("FAIL spur_setup got=%b if_rdata=%h expected 1/00500093", got, if_rdata);
    end
    tick();
    if_req = 1'b0;
    rsp_enable = 1'b0;
    man_ready = 1'b1; man_rvalid = 1'b1; man_rdata = 32'hFFFF_FFFF;
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      man_ready = 1'b0; man_rvalid = 1'b0;
      if (if_valid || dm_valid || mem_req || dbg_state !== ST_IDLE) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL spur_activity pulse or state change seen expected idle");
    end
    checks++;
    if (if_rdata !== 32'h0050_0093 || dm_rdata !== 32'h0) begin
      errors++; $display("FAIL spur_rdata if=%h dm=%h expected 00500093/00000000", if_rdata, dm_rdata);
    end
  endtask

  task automatic test_random();
    bit got;
    int op;
    logic [31:0] a, d, exp, exp_dm_rdata;
    rsp_enable = 1'b1;
    exp_dm_rdata = 32'h0;
    for (int n = 0; n < 12; n++) begin
      op = $urandom_range(0, 2);
      a = 32'h400 + 32'($urandom_range(0, 3)) * 4;
      ready_delay = $urandom_range(0, 3);
      rvalid_delay = $urandom_range(0, 3);
      if (op == 0) begin
        exp_q.push_back(shadow_rd(a));
        if_addr = a; if_req = 1'b1;
      end else if (op == 1) begin
        exp_q.push_back(shadow_rd(a));
        dm_addr = a; dm_we = 1'b0; dm_req = 1'b1;
      end else begin
        d = $urandom;
        shadow[a] = d;
        exp_q.push_back(exp_dm_rdata);
        dm_addr = a; dm_we = 1'b1; dm_wdata = d; dm_req = 1'b1;
      end
      wait_valid(op != 0, 30, got);
      checks++;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      if (!got) begin
        errors++; $display("FAIL rand%0d_timeout op=%0d no valid within 30 cycles", n, op);
      end else if ((op == 0 && (if_rdata !== exp || dm_valid)) || (op != 0 && (dm_rdata !== exp || if_valid))) begin
        errors++; $display("FAIL rand%0d_data op=%0d if=%h dm=%h expected %h", n, op, if_rdata, dm_rdata, exp);
      end
      if (op == 1) exp_dm_rdata = exp;
      tick();
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    end
  endtask

  // Main sequence
  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    rsp_enable = 1'b0; ready_delay = 0; rvalid_delay = 0;
    man_ready = 1'b0; man_rvalid = 1'b0; man_rdata = '0;
    test_reset();
    test_if_fetch();
    test_dm_priority();
    test_starvation();
    test_store_wait();
    test_reset_mid();
    test_spurious();
    test_random();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
